// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan
// Purpose  : Eight-digit seven-segment scan controller. Holds a CPU-written
//            32-bit display value and digit-enable mask, time-multiplexes the
//            digits and emits a {valid, nibble} code plus active-low selects.
// Revision : 1.0
// ============================================================================
module seg_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [1:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic [4:0]  code,
    output logic [7:0]  an,
    output logic        frame_tick
);

    localparam int                c_cnt_w    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_blank    = c_cnt_w'(BLANK_CYC);

    logic [31:0]        r_data;
    logic [7:0]         r_mask;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_idx;

    logic               w_blank;
    logic               w_lit;
    logic               w_cnt_wrap;
    logic [3:0]         w_nibble;
    logic [7:0]         w_an_next;
    logic [4:0]         w_code_next;
    logic [15:0]        w_rd_next;

    // A zero-length blank phase would make the comparison constant-false.
    generate
        if (BLANK_CYC > 0) begin : g_blank
            assign w_blank = (r_cnt < c_blank);
        end else begin : g_no_blank
            assign w_blank = 1'b0;
        end
    endgenerate

    assign w_cnt_wrap  = (r_cnt == c_cnt_last);
    assign w_nibble    = r_data[{r_idx, 2'b00} +: 4];
    assign w_lit       = ~w_blank & r_mask[r_idx];
    assign w_an_next   = w_lit ? ~(8'd1 << r_idx) : 8'hFF;
    assign w_code_next = w_lit ? {1'b1, w_nibble} : 5'h00;

    always_comb begin
        w_rd_next = 16'h0000;
        case (rd_addr)
            2'd0:    w_rd_next = r_data[15:0];
            2'd1:    w_rd_next = r_data[31:16];
            2'd2:    w_rd_next = {8'h00, r_mask};
            default: w_rd_next = 16'h0000;
        endcase
    end

    // Outputs are computed from pre-edge state, so writes show up one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= 32'h0000_0000;
            r_mask     <= 8'hFF;
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            an         <= 8'hFF;
            code       <= 5'h00;
            frame_tick <= 1'b0;
            rd_data    <= 16'h0000;
        end else begin
            if (w_cnt_wrap) begin
                r_cnt <= '0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end

            an         <= w_an_next;
            code       <= w_code_next;
            frame_tick <= w_cnt_wrap & (r_idx == 3'd7);
            rd_data    <= w_rd_next;

            if (wr_en) begin
                case (wr_addr)
                    2'd0:    r_data[15:0]  <= wr_data;
                    2'd1:    r_data[31:16] <= wr_data;
                    2'd2:    r_mask        <= wr_data[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan
// Purpose  : Self-checking bench for seg_scan with a cycle-level scoreboard.
// Revision : 1.0
// ============================================================================
module tb_seg_scan;

    localparam int SD = 4;
    localparam int BC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic [4:0]  code;
    logic [7:0]  an;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  an;
        logic [4:0]  code;
        logic        tick;
        logic [15:0] rd;
    } exp_t;

    exp_t sb[$];

    // Behavioural reference state
    logic [31:0] m_data = 32'h0;
    logic [7:0]  m_mask = 8'hFF;
    int          m_cnt  = 0;
    int          m_idx  = 0;

    seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .code       (code),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: push the expected registered outputs, clock, pop and compare.
    task automatic step();
        exp_t e, got;
        if (rst) begin
            e = '{an: 8'hFF, code: 5'h00, tick: 1'b0, rd: 16'h0000};
        end else begin
            if (m_cnt < BC || !m_mask[m_idx]) begin
                e.an   = 8'hFF;
                e.code = 5'h00;
            end else begin
                e.an   = ~(8'd1 << m_idx);
                e.code = {1'b1, 4'((m_data >> (4 * m_idx)) & 32'hF)};
            end
            e.tick = (m_cnt == SD - 1) && (m_idx == 7);
            case (rd_addr)
                2'd0:    e.rd = m_data[15:0];
                2'd1:    e.rd = m_data[31:16];
                2'd2:    e.rd = {8'h00, m_mask};
                default: e.rd = 16'h0000;
            endcase
        end
        sb.push_back(e);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("sb_an",   {24'h0, an},         {24'h0, got.an});
        chk("sb_code", {27'h0, code},       {27'h0, got.code});
        chk("sb_tick", {31'h0, frame_tick}, {31'h0, got.tick});
        chk("sb_rd",   {16'h0, rd_data},    {16'h0, got.rd});

        if (rst) begin
            m_data = 32'h0; m_mask = 8'hFF; m_cnt = 0; m_idx = 0;
        end else begin
            if (m_cnt == SD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_cnt = m_cnt + 1;
            end
            if (wr_en) begin
                case (wr_addr)
                    2'd0: m_data[15:0]  = wr_data;
                    2'd1: m_data[31:16] = wr_data;
                    2'd2: m_mask        = wr_data[7:0];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        int ticks;
        logic [7:0] seen;
        int guard;

        rst = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'h0; rd_addr = 2'd0;

        // 1. Reset defaults and blank/lit pattern per slot
        repeat (3) step();
        chk("rst_an", {24'h0, an}, 32'hFF);
        chk("rst_code", {27'h0, code}, 32'h0);
        rst = 1'b0;
        step();
        chk("first_blank_an", {24'h0, an}, 32'hFF);
        step();
        chk("digit0_an", {24'h0, an}, 32'hFE);
        chk("digit0_code", {27'h0, code}, 32'h10);
        repeat (30) step();
        chk("frame_tick_first", {31'h0, frame_tick}, 32'h1);

        // 2. Data display over one full frame
        wr(2'd0, 16'h3210);
        wr(2'd1, 16'h7654);
        ticks = 0; seen = 8'h00;
        for (int i = 0; i < 32; i++) begin
            step();
            if (frame_tick) ticks++;
            for (int d = 0; d < 8; d++)
                if (an == ~(8'd1 << d) && code == 5'(5'h10 + d)) seen[d] = 1'b1;
        end
        chk("frame_ticks_32", ticks, 1);
        chk("digits_seen", {24'h0, seen}, 32'hFF);

        // 3. Mask: only digits 0 and 2
        rd_addr = 2'd2;
        wr(2'd2, 16'h0005);
        chk("mask_rd_old", {16'h0, rd_data}, 32'h00FF);
        step();
        chk("mask_rd_new", {16'h0, rd_data}, 32'h0005);
        seen = 8'h00;
        for (int i = 0; i < 32; i++) begin
            step();
            seen = seen | ~an;
        end
        chk("mask_lit_set", {24'h0, seen}, 32'h05);
        wr(2'd2, 16'h00FF);

        // 4. Mid-slot write while digit 1 is lit
        guard = 0;
        while (!(m_idx == 1 && m_cnt == 2) && guard < 40) begin
            step();
            guard++;
        end
        chk("align_digit1", guard < 40, 1);
        chk("pre_write_code", {27'h0, code}, 32'h11);
        wr(2'd0, 16'hABCD);
        chk("write_edge_code", {27'h0, code}, 32'h11);
        step();
        chk("after_write_code", {27'h0, code}, 32'h1C);
        chk("after_write_an", {24'h0, an}, 32'hFD);
        step();
        chk("slot_boundary_blank", {24'h0, an}, 32'hFF);

        // 5. Read/write collision and reserved address
        rd_addr = 2'd1;
        step();
        chk("rd1_before", {16'h0, rd_data}, 32'h7654);
        wr(2'd1, 16'hBEEF);
        chk("collide_old", {16'h0, rd_data}, 32'h7654);
        step();
        chk("collide_new", {16'h0, rd_data}, 32'hBEEF);
        wr(2'd3, 16'hFFFF);
        rd_addr = 2'd3; step();
        chk("rd3_zero", {16'h0, rd_data}, 32'h0);
        rd_addr = 2'd0; step();
        chk("rd0_after_res", {16'h0, rd_data}, 32'hABCD);
        rd_addr = 2'd1; step();
        chk("rd1_after_res", {16'h0, rd_data}, 32'hBEEF);
        rd_addr = 2'd2; step();
        chk("rd2_after_res", {16'h0, rd_data}, 32'h00FF);

        // 6. Reset mid-frame with a concurrent write
        guard = 0;
        while (!(m_idx == 5 && m_cnt == 2) && guard < 40) begin
            step();
            guard++;
        end
        chk("align_idx5", guard < 40, 1);
        rd_addr = 2'd0;
        rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'h1234;
        step();
        rst = 1'b0; wr_en = 1'b0;
        chk("midrst_an", {24'h0, an}, 32'hFF);
        chk("midrst_code", {27'h0, code}, 32'h0);
        chk("midrst_tick", {31'h0, frame_tick}, 32'h0);
        chk("midrst_rd", {16'h0, rd_data}, 32'h0);
        step();
        chk("write_dropped", {16'h0, rd_data}, 32'h0);
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (frame_tick) ticks++;
        end
        chk("no_early_tick", ticks, 0);
        step();
        chk("tick_after_reset_frame", {31'h0, frame_tick}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
